// File: rtl/dca_booth_accumulator_pkg.sv
// Shared definitions for the DCA Booth accumulator: state encoding and width helpers.
// Optional protocol checking in the top is enabled by DCA_BOOTH_ACC_PROTOCOL_CHECK_EN.
package dca_booth_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } acc_state_e;

  function automatic int unsigned cnt_width(input int unsigned count);
    return (count > 32'd1) ? $clog2(count) : 32'd1;
  endfunction

  function automatic int unsigned acc_width(input int unsigned mcand_w,
                                            input int unsigned row_cnt,
                                            input int unsigned col_cnt);
    return mcand_w + row_cnt + col_cnt;
  endfunction

endpackage

// File: rtl/dca_booth_position_tracker.sv
// Row/column bit-position counters for the Booth accumulator, with saturation flags.
module dca_booth_position_tracker
  import dca_booth_accumulator_pkg::*;
#(
  parameter int unsigned ROW_COUNT = 8,
  parameter int unsigned COL_COUNT = 9,
  localparam int unsigned ROW_W = cnt_width(ROW_COUNT),
  localparam int unsigned COL_W = cnt_width(COL_COUNT)
) (
  input  logic             clk,
  input  logic             rstnn,
  input  logic             init,
  input  logic             enable,
  input  logic             step,
  input  logic             row_adv,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             row_sat,
  output logic             col_sat
);

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROW_COUNT - 32'd1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COL_COUNT - 32'd1);

  logic [ROW_W-1:0] row_r;
  logic [COL_W-1:0] col_r;

  // Position counters: init clears, row advance beats column step, both hold at max
  always_ff @(posedge clk) begin
    if (!rstnn) begin
      row_r <= '0;
      col_r <= '0;
    end else if (init) begin
      row_r <= '0;
      col_r <= '0;
    end else if (enable && row_adv) begin
      if (row_r != ROW_MAX) begin
        row_r <= row_r + 1'b1;
      end
      col_r <= '0;
    end else if (enable && step && (col_r != COL_MAX)) begin
      col_r <= col_r + 1'b1;
    end
  end

  assign row     = row_r;
  assign col     = col_r;
  assign row_sat = enable && row_adv && (row_r == ROW_MAX);
  assign col_sat = enable && !row_adv && step && (col_r == COL_MAX);

endmodule

// File: rtl/dca_booth_accumulator.sv
// Booth event accumulator: turns sequencer pulses into a signed product on a valid/ready port.
// Define DCA_BOOTH_ACC_PROTOCOL_CHECK_EN to add the sticky protocol_error output.
module dca_booth_accumulator
  import dca_booth_accumulator_pkg::*;
#(
  parameter int unsigned MCAND_WIDTH = 8,
  parameter int unsigned ROW_COUNT   = 8,
  parameter int unsigned COL_COUNT   = 9,
  localparam int unsigned ACC_WIDTH  = acc_width(MCAND_WIDTH, ROW_COUNT, COL_COUNT)
) (
  input  logic                   clk,
  input  logic                   rstnn,
  input  logic                   enable,
  input  logic                   init,
  input  logic [MCAND_WIDTH-1:0] multiplicand,
  input  logic                   add_pulse,
  input  logic                   sub_pulse,
  input  logic                   add_last,
  input  logic                   sub_last,
  input  logic                   step_pulse,
  input  logic                   row_pulse,
  input  logic                   done_pulse,
  output logic [ACC_WIDTH-1:0]   result,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   busy
`ifdef DCA_BOOTH_ACC_PROTOCOL_CHECK_EN
  ,
  output logic                   protocol_error
`endif
);

  localparam int unsigned ROW_W   = cnt_width(ROW_COUNT);
  localparam int unsigned COL_W   = cnt_width(COL_COUNT);
  localparam int unsigned SHIFT_W = cnt_width(ROW_COUNT + COL_COUNT - 32'd1);

  acc_state_e             state_r, state_next_s;
  logic [MCAND_WIDTH-1:0] mcand_r;
  logic [ACC_WIDTH-1:0]   acc_r, acc_next_s, mcand_ext_s, term_s, result_r;
  logic                   result_valid_r, busy_r;
  logic [ROW_W-1:0]       row_s;
  logic [COL_W-1:0]       col_s;
  logic [SHIFT_W-1:0]     shift_s;
  logic                   row_sat_s, col_sat_s, ev_en_s;

  // Events count only in RUN, when enabled, and never in an init cycle
  assign ev_en_s     = (state_r == ST_RUN) && enable && !init;
  assign shift_s     = SHIFT_W'(row_s) + SHIFT_W'(col_s);
  assign mcand_ext_s = {{(ACC_WIDTH - MCAND_WIDTH){mcand_r[MCAND_WIDTH-1]}}, mcand_r};
  assign term_s      = mcand_ext_s << shift_s;

  dca_booth_position_tracker #(
    .ROW_COUNT (ROW_COUNT),
    .COL_COUNT (COL_COUNT)
  ) u_position (
    .clk     (clk),
    .rstnn   (rstnn),
    .init    (init),
    .enable  (ev_en_s),
    .step    (step_pulse),
    .row_adv (row_pulse),
    .row     (row_s),
    .col     (col_s),
    .row_sat (row_sat_s),
    .col_sat (col_sat_s)
  );

  // Booth add/sub of the shifted multiplicand at the pre-update position
  always_comb begin
    acc_next_s = acc_r;
    if (ev_en_s && add_pulse && !sub_pulse) begin
      acc_next_s = acc_r + term_s;
    end else if (ev_en_s && sub_pulse && !add_pulse) begin
      acc_next_s = acc_r - term_s;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Next-state logic; init restarts from any state
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (init) state_next_s = ST_RUN;
        else      state_next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (init)                         state_next_s = ST_RUN;
        else if (ev_en_s && done_pulse)   state_next_s = ST_HOLD;
        else                              state_next_s = ST_RUN;
      end
      ST_HOLD: begin
        if (init)              state_next_s = ST_RUN;
        else if (result_ready) state_next_s = ST_IDLE;
        else                   state_next_s = ST_HOLD;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstnn) state_r <= ST_IDLE;
    else        state_r <= state_next_s;
  end

  // Accumulator, latched multiplicand and registered result port
  always_ff @(posedge clk) begin
    if (!rstnn) begin
      acc_r          <= '0;
      mcand_r        <= '0;
      result_r       <= '0;
      result_valid_r <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      busy_r <= (state_next_s == ST_RUN);
      if (init) begin
        acc_r          <= '0;
        mcand_r        <= multiplicand;
        result_valid_r <= 1'b0;
      end else begin
        acc_r <= acc_next_s;
        if (ev_en_s && done_pulse) begin
          result_r       <= acc_next_s;
          result_valid_r <= 1'b1;
        end else if ((state_r == ST_HOLD) && result_ready) begin
          result_valid_r <= 1'b0;
        end
      end
    end
  end

  assign result       = result_r;
  assign result_valid = result_valid_r;
  assign busy         = busy_r;

`ifdef DCA_BOOTH_ACC_PROTOCOL_CHECK_EN
  logic add_open_r, sub_open_r, perr_r;
  logic any_event_s, add_live_s, sub_live_s, perr_hit_s;

  // A begin and its end may share a cycle, so "live" includes this cycle's begin
  always_comb begin
    any_event_s = add_pulse | sub_pulse | add_last | sub_last |
                  step_pulse | row_pulse | done_pulse;
    add_live_s  = add_open_r | add_pulse;
    sub_live_s  = sub_open_r | sub_pulse;
    perr_hit_s  = 1'b0;
    if (!enable || init) begin
      perr_hit_s = 1'b0;
    end else if (state_r != ST_RUN) begin
      perr_hit_s = any_event_s;
    end else begin
      perr_hit_s = (add_last && !add_live_s) || (sub_last && !sub_live_s) ||
                   (add_pulse && add_open_r) || (sub_pulse && sub_open_r) ||
                   ((step_pulse || row_pulse || done_pulse) &&
                    ((add_live_s && !add_last) || (sub_live_s && !sub_last))) ||
                   row_sat_s || col_sat_s;
    end
  end

  // Outstanding-op tracking and sticky error flag
  always_ff @(posedge clk) begin
    if (!rstnn || init) begin
      add_open_r <= 1'b0;
      sub_open_r <= 1'b0;
      perr_r     <= 1'b0;
    end else begin
      if (ev_en_s) begin
        add_open_r <= add_live_s && !add_last;
        sub_open_r <= sub_live_s && !sub_last;
      end
      if (perr_hit_s) perr_r <= 1'b1;
    end
  end

  assign protocol_error = perr_r;
`else
  logic unused_inputs_s;
  assign unused_inputs_s = ^{add_last, sub_last, row_sat_s, col_sat_s};
`endif

endmodule

// File: tb/tb_dca_booth_accumulator.sv
// Self-checking bench for dca_booth_accumulator: directed scenarios plus random events vs. an arithmetic model.
`timescale 1ns/1ps
module tb_dca_booth_accumulator;

  localparam int AW = 25;

  logic          clk = 1'b0;
  logic          rstnn, enable, init;
  logic [7:0]    multiplicand;
  logic          add_pulse, sub_pulse, add_last, sub_last;
  logic          step_pulse, row_pulse, done_pulse, result_ready;
  logic [AW-1:0] result;
  logic          result_valid, busy;
`ifdef DCA_BOOTH_ACC_PROTOCOL_CHECK_EN
  logic          protocol_error;
`endif

  int errors = 0;
  int checks = 0;

  // Behavioural model: product built as sum of +/- M * 2^(row+col)
  longint        m_acc = 0;
  longint        m_mcand = 0;
  int            m_row = 0, m_col = 0, m_phase = 0;   // phase: 0 idle, 1 running, 2 holding
  logic [AW-1:0] m_result = '0;
  bit            m_valid = 1'b0;

  dca_booth_accumulator dut (
    .clk          (clk),
    .rstnn        (rstnn),
    .enable       (enable),
    .init         (init),
    .multiplicand (multiplicand),
    .add_pulse    (add_pulse),
    .sub_pulse    (sub_pulse),
    .add_last     (add_last),
    .sub_last     (sub_last),
    .step_pulse   (step_pulse),
    .row_pulse    (row_pulse),
    .done_pulse   (done_pulse),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy)
`ifdef DCA_BOOTH_ACC_PROTOCOL_CHECK_EN
    ,
    .protocol_error (protocol_error)
`endif
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    enable = 1'b1; init = 1'b0; add_pulse = 1'b0; sub_pulse = 1'b0;
    add_last = 1'b0; sub_last = 1'b0; step_pulse = 1'b0; row_pulse = 1'b0;
    done_pulse = 1'b0; result_ready = 1'b0;
  endtask

  // Advance the model with the current inputs, then one clock; outputs sampled 1ns after the edge
  task automatic tick();
    if (!rstnn) begin
      m_acc = 0; m_mcand = 0; m_row = 0; m_col = 0; m_phase = 0;
      m_result = '0; m_valid = 1'b0;
    end else if (init) begin
      m_acc = 0; m_row = 0; m_col = 0; m_phase = 1; m_valid = 1'b0;
      m_mcand = longint'($signed(multiplicand));
    end else if (m_phase == 1 && enable) begin
      if (add_pulse != sub_pulse)
        m_acc = m_acc + (add_pulse ? m_mcand : -m_mcand) * (longint'(1) << (m_row + m_col));
      if (row_pulse) begin
        m_row = (m_row < 7) ? m_row + 1 : 7;
        m_col = 0;
      end else if (step_pulse) begin
        m_col = (m_col < 8) ? m_col + 1 : 8;
      end
      if (done_pulse) begin
        m_result = m_acc[AW-1:0];
        m_valid = 1'b1;
        m_phase = 2;
      end
    end else if (m_phase == 2 && result_ready) begin
      m_valid = 1'b0;
      m_phase = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_init(input logic [7:0] m);
    multiplicand = m; init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  task automatic drain();
    done_pulse = 1'b1; tick(); done_pulse = 1'b0;
    result_ready = 1'b1; tick(); result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstnn = 1'b0; clear_inputs(); multiplicand = 8'h00;
    tick(); tick();
    checks++; if (result !== 25'd0) begin errors++; $display("FAIL reset_result: got %0h expected 0", result); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
`ifdef DCA_BOOTH_ACC_PROTOCOL_CHECK_EN
    checks++; if (protocol_error !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", protocol_error); end
`endif
    rstnn = 1'b1;
  endtask

  task automatic test_basic_add();
    pulse_init(8'd3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
    add_pulse = 1'b1; tick(); add_pulse = 1'b0;
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", result_valid); end
    done_pulse = 1'b1; tick(); done_pulse = 1'b0;
    checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", result_valid); end
    checks++; if (result !== 25'd3) begin errors++; $display("FAIL basic_result: got %0h expected 3", result); end
    result_ready = 1'b1; tick(); result_ready = 1'b0;
    checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_accept: got valid=%b busy=%b expected 0 0", result_valid, busy); end
  endtask

  task automatic test_shifted_add();
    pulse_init(8'hFE);
    row_pulse = 1'b1; tick(); row_pulse = 1'b0;
    step_pulse = 1'b1; tick(); tick(); step_pulse = 1'b0;
    add_pulse = 1'b1; tick(); add_pulse = 1'b0;
    done_pulse = 1'b1; tick(); done_pulse = 1'b0;
    checks++; if (result !== 25'h1FFFFF0) begin errors++; $display("FAIL shifted_result: got %0h expected 1fffff0", result); end
    result_ready = 1'b1; tick(); result_ready = 1'b0;
  endtask

  task automatic test_add_sub_same();
    pulse_init(8'd5);
    add_pulse = 1'b1; sub_pulse = 1'b1; tick(); add_pulse = 1'b0; sub_pulse = 1'b0;
    done_pulse = 1'b1; tick(); done_pulse = 1'b0;
    checks++; if (result_valid !== 1'b1 || result !== 25'd0) begin errors++; $display("FAIL both_result: got valid=%b result=%0h expected 1 0", result_valid, result); end
    result_ready = 1'b1; tick(); result_ready = 1'b0;
  endtask

  task automatic test_hold_and_restart();
    pulse_init(8'd1);
    add_pulse = 1'b1; tick(); add_pulse = 1'b0;
    done_pulse = 1'b1; tick(); done_pulse = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (result_valid !== 1'b1 || result !== 25'd1) begin errors++; $display("FAIL hold_cycle%0d: got valid=%b result=%0h expected 1 1", i, result_valid, result); end
      tick();
    end
    init = 1'b1; result_ready = 1'b1; multiplicand = 8'd1;
    tick();
    init = 1'b0; result_ready = 1'b0;
    checks++; if (result_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL hold_restart: got valid=%b busy=%b expected 0 1", result_valid, busy); end
    drain();
  endtask

  task automatic test_abort();
    pulse_init(8'd7);
    add_pulse = 1'b1; tick(); tick(); add_pulse = 1'b0;
    rstnn = 1'b0; tick(); rstnn = 1'b1;
    checks++; if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 25'd0) begin errors++; $display("FAIL abort_state: got busy=%b valid=%b result=%0h expected 0 0 0", busy, result_valid, result); end
    done_pulse = 1'b1; tick(); done_pulse = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL abort_no_result%0d: got %b expected 0", i, result_valid); end
      tick();
    end
  endtask

  task automatic test_saturation();
    pulse_init(8'd1);
    row_pulse = 1'b1; repeat (10) tick(); row_pulse = 1'b0;
    step_pulse = 1'b1; repeat (12) tick(); step_pulse = 1'b0;
    add_pulse = 1'b1; tick(); add_pulse = 1'b0;
    done_pulse = 1'b1; tick(); done_pulse = 1'b0;
    checks++; if (result !== 25'h0008000) begin errors++; $display("FAIL saturated_result: got %0h expected 8000", result); end
    result_ready = 1'b1; tick(); result_ready = 1'b0;
  endtask

  task automatic test_enable_gate();
    pulse_init(8'd9);
    enable = 1'b0; add_pulse = 1'b1; done_pulse = 1'b1; tick();
    add_pulse = 1'b0; done_pulse = 1'b0; enable = 1'b1;
    checks++; if (result_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL enable_gate: got valid=%b busy=%b expected 0 1", result_valid, busy); end
    sub_pulse = 1'b1; step_pulse = 1'b1; tick(); sub_pulse = 1'b0; step_pulse = 1'b0;
    drain();
    checks++; if (result !== 25'h1FFFFF7) begin errors++; $display("FAIL enable_result: got %0h expected 1fffff7", result); end
  endtask

`ifdef DCA_BOOTH_ACC_PROTOCOL_CHECK_EN
  task automatic test_protocol();
    pulse_init(8'd2);
    checks++; if (protocol_error !== 1'b0) begin errors++; $display("FAIL perr_after_init: got %b expected 0", protocol_error); end
    add_last = 1'b1; tick(); add_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (protocol_error !== 1'b1) begin errors++; $display("FAIL perr_sticky%0d: got %b expected 1", i, protocol_error); end
      tick();
    end
    pulse_init(8'd2);
    checks++; if (protocol_error !== 1'b0) begin errors++; $display("FAIL perr_cleared: got %b expected 0", protocol_error); end
    drain();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      rstnn        = ($urandom_range(0, 199) != 0);
      enable       = ($urandom_range(0, 99) < 85);
      init         = (m_phase == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 99) < 3);
      multiplicand = 8'($urandom());
      add_pulse    = ($urandom_range(0, 99) < 30);
      sub_pulse    = ($urandom_range(0, 99) < 30);
      step_pulse   = ($urandom_range(0, 99) < 30);
      row_pulse    = ($urandom_range(0, 99) < 10);
      done_pulse   = ($urandom_range(0, 99) < 5);
      result_ready = ($urandom_range(0, 99) < 50);
      tick();
      checks++; if (result_valid !== m_valid) begin errors++; $display("FAIL rand_valid@%0d: got %b expected %b", i, result_valid, m_valid); end
      checks++; if (busy !== (m_phase == 1)) begin errors++; $display("FAIL rand_busy@%0d: got %b expected %b", i, busy, (m_phase == 1)); end
      if (m_valid) begin
        checks++; if (result !== m_result) begin errors++; $display("FAIL rand_result@%0d: got %0h expected %0h", i, result, m_result); end
      end
    end
    clear_inputs();
    rstnn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_shifted_add();
    test_add_sub_same();
    test_hold_and_restart();
    test_abort();
    test_saturation();
    test_enable_gate();
`ifdef DCA_BOOTH_ACC_PROTOCOL_CHECK_EN
    test_protocol();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
